// File: rtl/debug_run_controller_pkg.sv
// Shared types for the pipeline run-control sequencer: FSM states, halt causes,
// default sizing for the in-flight counter.
package debug_run_controller_pkg;

   localparam int DEF_PC_WIDTH   = 32;
   localparam int DEF_PIPE_DEPTH = 4;
   localparam int DEF_CNT_WIDTH  = 32;
   localparam int DEF_IF_WIDTH   = $clog2(DEF_PIPE_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_DRAIN      = 3'd1,
      ST_HALT       = 3'd2,
      ST_STEP       = 3'd3,
      ST_STEP_DRAIN = 3'd4
   } debug_run_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_HALTREQ    = 2'd1,
      CAUSE_BREAKPOINT = 2'd2,
      CAUSE_STEP       = 2'd3
   } halt_cause_e;

   typedef logic [DEF_IF_WIDTH-1:0] inflight_count_t;

endpackage

// File: rtl/debug_run_controller_if.sv
// Debug host / pipeline bundle seen by the run controller. The master side drives
// requests and pipeline events; the slave side is the controller.
interface debug_run_controller_if #(
   parameter int PC_WIDTH   = 32,
   parameter int PIPE_DEPTH = 4,
   parameter int CNT_WIDTH  = 32
) ();
   localparam int IF_W = $clog2(PIPE_DEPTH + 1);

   logic                haltReq;
   logic                resumeReq;
   logic                stepReq;
   logic                bpEnable;
   logic [PC_WIDTH-1:0] bpAddr;
   logic                fetchValid;
   logic [PC_WIDTH-1:0] fetchPC;
   logic                retireValid;
   logic [PC_WIDTH-1:0] retirePC;
   logic [IF_W-1:0]     squashCount;

   logic                 fetchEnable;
   logic                 halted;
   logic [1:0]           haltCause;
   logic [PC_WIDTH-1:0]  lastRetiredPC;
   logic [CNT_WIDTH-1:0] retiredCount;
   logic [IF_W-1:0]      inFlight;

   modport master (
      output haltReq, resumeReq, stepReq, bpEnable, bpAddr,
             fetchValid, fetchPC, retireValid, retirePC, squashCount,
      input  fetchEnable, halted, haltCause, lastRetiredPC, retiredCount, inFlight
   );

   modport slave (
      input  haltReq, resumeReq, stepReq, bpEnable, bpAddr,
             fetchValid, fetchPC, retireValid, retirePC, squashCount,
      output fetchEnable, halted, haltCause, lastRetiredPC, retiredCount, inFlight
   );
endinterface

// File: rtl/debug_inflight_counter.sv
// Tracks instructions between fetch and writeback: +issue, -retire, -squash,
// all of which may land in the same cycle.
module debug_inflight_counter #(
   parameter int PIPE_DEPTH = 4,
   localparam int W = $clog2(PIPE_DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         issue,
   input  logic         retire,
   input  logic [W-1:0] squash,
   output logic [W-1:0] count
);
   localparam logic signed [W+1:0] MAX_CNT = (W+2)'(PIPE_DEPTH);

   logic [W-1:0]        count_q, count_d;
   logic signed [W+1:0] next_wide;

   // Two guard bits so underflow shows up as a negative value instead of wrapping.
   always_comb begin
      next_wide = $signed({2'b00, count_q})
                + $signed({{(W+1){1'b0}}, issue})
                - $signed({{(W+1){1'b0}}, retire})
                - $signed({2'b00, squash});
      count_d   = next_wide[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
         assert (!next_wide[W+1] && (next_wide <= MAX_CNT));
      end
   end

   assign count = count_q;
endmodule

// File: rtl/debug_run_controller.sv
// Run-control sequencer: gates fetch, drains the pipe on halt/breakpoint,
// single-steps from HALT and keeps retire statistics for the debug host.
module debug_run_controller
   import debug_run_controller_pkg::*;
#(
   parameter int PC_WIDTH   = 32,
   parameter int PIPE_DEPTH = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   debug_run_controller_if.slave  dbg
);
   localparam int IF_W = $clog2(PIPE_DEPTH + 1);

   debug_run_state_e     state_q, state_d;
   halt_cause_e          cause_q, cause_d;
   logic                 bp_skip_q, bp_skip_d;
   logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
   logic [CNT_WIDTH-1:0] ret_cnt_q, ret_cnt_d;

   logic            bp_hit;
   logic            fetch_en;
   logic            fetch_issue;
   logic [IF_W-1:0] in_flight;

   debug_inflight_counter #(.PIPE_DEPTH(PIPE_DEPTH)) u_inflight (
      .clk    (clk),
      .rst    (rst),
      .issue  (fetch_issue),
      .retire (dbg.retireValid),
      .squash (dbg.squashCount),
      .count  (in_flight)
   );

   always_comb begin
      bp_hit = dbg.bpEnable & dbg.fetchValid & (dbg.fetchPC == dbg.bpAddr) & !bp_skip_q;
      case (state_q)
         ST_RUN:  fetch_en = !bp_hit & !dbg.haltReq;
         ST_STEP: fetch_en = 1'b1;
         default: fetch_en = 1'b0;
      endcase
      fetch_issue = dbg.fetchValid & fetch_en;
   end

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      bp_skip_d = bp_skip_q;

      if (fetch_issue) bp_skip_d = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (bp_hit) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_BREAKPOINT;
            end else if (dbg.haltReq) begin
               state_d = ST_DRAIN;
               cause_d = CAUSE_HALTREQ;
            end
         end
         ST_DRAIN: begin
            if (in_flight == '0) state_d = ST_HALT;
         end
         ST_HALT: begin
            // Leaving a breakpoint halt must let the trapped instruction through once.
            if (dbg.resumeReq) begin
               state_d   = ST_RUN;
               cause_d   = CAUSE_NONE;
               bp_skip_d = (cause_q == CAUSE_BREAKPOINT);
            end else if (dbg.stepReq) begin
               state_d   = ST_STEP;
               bp_skip_d = (cause_q == CAUSE_BREAKPOINT);
            end
         end
         ST_STEP: begin
            if (fetch_issue) state_d = ST_STEP_DRAIN;
         end
         ST_STEP_DRAIN: begin
            if (in_flight == '0) begin
               state_d = ST_HALT;
               cause_d = CAUSE_STEP;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      last_pc_d = last_pc_q;
      ret_cnt_d = ret_cnt_q;
      if (dbg.retireValid) begin
         last_pc_d = dbg.retirePC;
         ret_cnt_d = ret_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         cause_q   <= CAUSE_NONE;
         bp_skip_q <= 1'b0;
         last_pc_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         bp_skip_q <= bp_skip_d;
         last_pc_q <= last_pc_d;
         ret_cnt_q <= ret_cnt_d;
      end
   end

   assign dbg.fetchEnable   = fetch_en;
   assign dbg.halted        = (state_q == ST_HALT);
   assign dbg.haltCause     = cause_q;
   assign dbg.lastRetiredPC = last_pc_q;
   assign dbg.retiredCount  = ret_cnt_q;
   assign dbg.inFlight      = in_flight;
endmodule

// File: tb/tb_debug_run_controller.sv
// Vector-table bench for the run controller: each record drives one cycle, checks
// fetchEnable combinationally and queues the expected post-edge state for comparison.
module tb_debug_run_controller;
   logic clk;
   logic rst;

   debug_run_controller_if #(.PC_WIDTH(32), .PIPE_DEPTH(4), .CNT_WIDTH(32)) dbg_if ();

   debug_run_controller #(.PC_WIDTH(32), .PIPE_DEPTH(4), .CNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .dbg (dbg_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        h, r, s, be;
      logic [31:0] bpa;
      logic        fv;
      logic [31:0] fpc;
      logic        rv;
      logic [31:0] rpc;
      logic [2:0]  sq;
      logic        e_fe;
      logic        e_hl;
      logic [1:0]  e_cause;
      logic [2:0]  e_inf;
      logic [31:0] e_cnt;
      logic [31:0] e_lpc;
   } vec_t;

   typedef struct {
      int          idx;
      logic        hl;
      logic [1:0]  cause;
      logic [2:0]  inf;
      logic [31:0] cnt;
      logic [31:0] lpc;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs[$];
   exp_t exp_q[$];

   function automatic vec_t mk(input logic h, r, s, be, input logic [31:0] bpa,
                               input logic fv, input logic [31:0] fpc,
                               input logic rv, input logic [31:0] rpc, input logic [2:0] sq,
                               input logic fe, hl, input logic [1:0] c, input logic [2:0] inf,
                               input logic [31:0] cnt, lpc);
      vec_t v;
      v.h = h; v.r = r; v.s = s; v.be = be; v.bpa = bpa;
      v.fv = fv; v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.sq = sq;
      v.e_fe = fe; v.e_hl = hl; v.e_cause = c; v.e_inf = inf; v.e_cnt = cnt; v.e_lpc = lpc;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [vec %0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      dbg_if.haltReq     = v.h;
      dbg_if.resumeReq   = v.r;
      dbg_if.stepReq     = v.s;
      dbg_if.bpEnable    = v.be;
      dbg_if.bpAddr      = v.bpa;
      dbg_if.fetchValid  = v.fv;
      dbg_if.fetchPC     = v.fpc;
      dbg_if.retireValid = v.rv;
      dbg_if.retirePC    = v.rpc;
      dbg_if.squashCount = v.sq;
   endtask

   task automatic compare_post(input exp_t e);
      check("halted",        e.idx, 32'(dbg_if.halted),     32'(e.hl));
      check("haltCause",     e.idx, 32'(dbg_if.haltCause),  32'(e.cause));
      check("inFlight",      e.idx, 32'(dbg_if.inFlight),   32'(e.inf));
      check("retiredCount",  e.idx, dbg_if.retiredCount,    e.cnt);
      check("lastRetiredPC", e.idx, dbg_if.lastRetiredPC,   e.lpc);
   endtask

   // Drive at negedge, sample fetchEnable just before posedge, compare state after it.
   task automatic apply(input int idx, input vec_t v);
      exp_t e;
      @(negedge clk);
      drive(v);
      #4;
      check("fetchEnable", idx, 32'(dbg_if.fetchEnable), 32'(v.e_fe));
      e.idx = idx; e.hl = v.e_hl; e.cause = v.e_cause; e.inf = v.e_inf;
      e.cnt = v.e_cnt; e.lpc = v.e_lpc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard [vec %0d]: queue empty", idx);
      end else begin
         compare_post(exp_q.pop_front());
      end
   endtask

   initial begin
      exp_t e;
      vec_t idle;
      idle = mk(0,0,0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0);
      drive(idle);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e.idx = -1; e.hl = 0; e.cause = 0; e.inf = 0; e.cnt = 0; e.lpc = 0;
      compare_post(e);
      check("fetchEnable_reset", -1, 32'(dbg_if.fetchEnable), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      //        h r s be bpa     fv fpc     rv rpc     sq  fe hl c inf cnt lpc
      // halt with empty pipe
      vecs.push_back(mk(1,0,0,0,0,      0,0,      0,0,      0,  0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,      0,0,      0,0,      0,  0,1,1,0,0,0));
      vecs.push_back(mk(0,1,0,0,0,      0,0,      0,0,      0,  0,0,0,0,0,0));
      // halt with three in flight
      vecs.push_back(mk(0,0,0,0,0,      1,'h10,   0,0,      0,  1,0,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,      1,'h14,   0,0,      0,  1,0,0,2,0,0));
      vecs.push_back(mk(0,0,0,0,0,      1,'h18,   0,0,      0,  1,0,0,3,0,0));
      vecs.push_back(mk(1,0,0,0,0,      1,'h1c,   0,0,      0,  0,0,1,3,0,0));
      vecs.push_back(mk(0,0,0,0,0,      0,0,      1,'h10,   0,  0,0,1,2,1,'h10));
      vecs.push_back(mk(0,0,0,0,0,      0,0,      1,'h14,   0,  0,0,1,1,2,'h14));
      vecs.push_back(mk(0,0,0,0,0,      0,0,      1,'h18,   0,  0,0,1,0,3,'h18));
      vecs.push_back(mk(0,0,0,0,0,      0,0,      0,0,      0,  0,1,1,0,3,'h18));
      vecs.push_back(mk(0,1,0,0,0,      0,0,      0,0,      0,  0,0,0,0,3,'h18));
      // breakpoint, resume with skip, re-trigger
      vecs.push_back(mk(0,0,0,1,'h100,  1,'h100,  0,0,      0,  0,0,2,0,3,'h18));
      vecs.push_back(mk(0,0,0,1,'h100,  0,0,      0,0,      0,  0,1,2,0,3,'h18));
      vecs.push_back(mk(0,1,0,1,'h100,  1,'h100,  0,0,      0,  0,0,0,0,3,'h18));
      vecs.push_back(mk(0,0,0,1,'h100,  1,'h100,  0,0,      0,  1,0,0,1,3,'h18));
      vecs.push_back(mk(0,0,0,1,'h100,  1,'h100,  1,'h100,  0,  0,0,2,0,4,'h100));
      vecs.push_back(mk(0,0,0,1,'h100,  0,0,      0,0,      0,  0,1,2,0,4,'h100));
      // single step, waiting on fetchValid, breakpoint ignored while stepping
      vecs.push_back(mk(0,0,1,1,'h100,  0,0,      0,0,      0,  0,0,2,0,4,'h100));
      vecs.push_back(mk(0,0,0,1,'h100,  0,0,      0,0,      0,  1,0,2,0,4,'h100));
      vecs.push_back(mk(0,0,0,1,'h100,  1,'h100,  0,0,      0,  1,0,2,1,4,'h100));
      vecs.push_back(mk(0,0,0,1,'h100,  1,'h104,  0,0,      0,  0,0,2,1,4,'h100));
      vecs.push_back(mk(0,0,0,1,'h100,  0,0,      1,'h100,  0,  0,0,2,0,5,'h100));
      vecs.push_back(mk(0,0,0,1,'h100,  0,0,      0,0,      0,  0,1,3,0,5,'h100));
      // resume and step together: resume wins
      vecs.push_back(mk(0,1,1,1,'h100,  0,0,      0,0,      0,  0,0,0,0,5,'h100));
      // issue + retire + squash in one cycle
      vecs.push_back(mk(0,0,0,0,0,      1,'h200,  0,0,      0,  1,0,0,1,5,'h100));
      vecs.push_back(mk(0,0,0,0,0,      1,'h204,  0,0,      0,  1,0,0,2,5,'h100));
      vecs.push_back(mk(0,0,0,0,0,      1,'h208,  1,'h200,  1,  1,0,0,1,6,'h200));
      vecs.push_back(mk(0,0,0,0,0,      0,0,      0,0,      1,  1,0,0,0,6,'h200));
      // fill two, then halt so reset lands mid-drain
      vecs.push_back(mk(0,0,0,0,0,      1,'h300,  0,0,      0,  1,0,0,1,6,'h200));
      vecs.push_back(mk(0,0,0,0,0,      1,'h304,  0,0,      0,  1,0,0,2,6,'h200));
      vecs.push_back(mk(1,0,0,0,0,      0,0,      0,0,      0,  0,0,1,2,6,'h200));

      foreach (vecs[i]) apply(i, vecs[i]);

      // reset during DRAIN with a retire in the same cycle: everything cleared
      @(negedge clk);
      drive(mk(0,0,0,0,0, 0,0, 1,'h400,0, 0,0,0,0,0,0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      e.idx = 100; e.hl = 0; e.cause = 0; e.inf = 0; e.cnt = 0; e.lpc = 0;
      compare_post(e);
      @(negedge clk);
      rst = 1'b1;
      drive(idle);
      #4;
      check("fetchEnable_after_reset", 101, 32'(dbg_if.fetchEnable), 32'd1);
      @(posedge clk);
      #1;
      check("halted_after_reset", 101, 32'(dbg_if.halted), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
